// File: rtl/bcd_multi_counter_if.sv
// Control/data bundle between the game controller and the BCD counter.
// Nibble i of load_value and digits_out is decimal digit i.
interface bcd_multi_counter_if #(
    parameter int DIGITS = 4
);
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  inc;
    logic                  dec;
    logic [4*DIGITS-1:0]   digits_out;
    logic                  overflow;
    logic                  underflow;
    logic                  at_max;
    logic                  at_zero;

    modport master (
        output clr, load, load_value, inc, dec,
        input  digits_out, overflow, underflow, at_max, at_zero
    );

    modport slave (
        input  clr, load, load_value, inc, dec,
        output digits_out, overflow, underflow, at_max, at_zero
    );
endinterface

// File: rtl/bcd_multi_counter.sv
// N-digit BCD up/down counter with clear, clamped parallel load,
// wrap or saturate at the boundaries, and registered overflow/underflow pulses.
module bcd_multi_counter #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_multi_counter_if.slave   bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLR,
        ACT_LOAD,
        ACT_INC,
        ACT_DEC
    } action_t;

    action_t      action;
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] inc_value;
    logic [W-1:0] dec_value;
    logic [W-1:0] load_clamped;
    logic         overflow_q;
    logic         overflow_d;
    logic         underflow_q;
    logic         underflow_d;
    logic         is_max;
    logic         is_zero;

    assign is_max  = (count_q == ALL_NINES);
    assign is_zero = (count_q == '0);

    // Decimal increment: carry ripples through the whole word in one cycle.
    always_comb begin : inc_chain
        logic carry;
        inc_value = count_q;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_value[4*i +: 4] = 4'd0;
                end else begin
                    inc_value[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin : dec_chain
        logic borrow;
        dec_value = count_q;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_value[4*i +: 4] = 4'd9;
                end else begin
                    dec_value[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    // Non-decimal load nibbles are pinned to 9 so no digit ever holds A..F.
    always_comb begin
        load_clamped = bus.load_value;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_value[4*i +: 4] > 4'd9) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin
        action = ACT_HOLD;
        if (bus.clr) begin
            action = ACT_CLR;
        end else if (bus.load) begin
            action = ACT_LOAD;
        end else if (bus.inc && !bus.dec) begin
            action = ACT_INC;
        end else if (bus.dec && !bus.inc) begin
            action = ACT_DEC;
        end
    end

    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        case (action)
            ACT_CLR:  count_d = '0;
            ACT_LOAD: count_d = load_clamped;
            ACT_INC: begin
                overflow_d = is_max;
                count_d    = (is_max && SATURATE) ? count_q : inc_value;
            end
            ACT_DEC: begin
                underflow_d = is_zero;
                count_d     = (is_zero && SATURATE) ? count_q : dec_value;
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.digits_out = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
    assign bus.at_max     = is_max;
    assign bus.at_zero    = is_zero;
endmodule

// File: tb/tb_bcd_multi_counter.sv
// Drives four counter configurations with shared stimulus and compares each
// against an integer-valued reference model of the decimal count.
module tb_bcd_multi_counter;
    localparam int NUM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        load;
    logic        inc;
    logic        dec;
    logic [31:0] load_value;

    always #5 clk = ~clk;

    bcd_multi_counter_if #(.DIGITS(4)) bus_4w ();
    bcd_multi_counter_if #(.DIGITS(4)) bus_4s ();
    bcd_multi_counter_if #(.DIGITS(1)) bus_1w ();
    bcd_multi_counter_if #(.DIGITS(8)) bus_8w ();

    assign bus_4w.clr = clr;  assign bus_4w.load = load;  assign bus_4w.inc = inc;  assign bus_4w.dec = dec;
    assign bus_4s.clr = clr;  assign bus_4s.load = load;  assign bus_4s.inc = inc;  assign bus_4s.dec = dec;
    assign bus_1w.clr = clr;  assign bus_1w.load = load;  assign bus_1w.inc = inc;  assign bus_1w.dec = dec;
    assign bus_8w.clr = clr;  assign bus_8w.load = load;  assign bus_8w.inc = inc;  assign bus_8w.dec = dec;
    assign bus_4w.load_value = load_value[15:0];
    assign bus_4s.load_value = load_value[15:0];
    assign bus_1w.load_value = load_value[3:0];
    assign bus_8w.load_value = load_value;

    bcd_multi_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_4w (.clk(clk), .rst_n(rst_n), .bus(bus_4w));
    bcd_multi_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_4s (.clk(clk), .rst_n(rst_n), .bus(bus_4s));
    bcd_multi_counter #(.DIGITS(1), .SATURATE(1'b0)) dut_1w (.clk(clk), .rst_n(rst_n), .bus(bus_1w));
    bcd_multi_counter #(.DIGITS(8), .SATURATE(1'b0)) dut_8w (.clk(clk), .rst_n(rst_n), .bus(bus_8w));

    logic [31:0] dut_count [NUM];
    logic        dut_ovf   [NUM];
    logic        dut_unf   [NUM];
    logic        dut_max   [NUM];
    logic        dut_zero  [NUM];

    assign dut_count[0] = {16'd0, bus_4w.digits_out};
    assign dut_count[1] = {16'd0, bus_4s.digits_out};
    assign dut_count[2] = {28'd0, bus_1w.digits_out};
    assign dut_count[3] = bus_8w.digits_out;
    assign dut_ovf[0] = bus_4w.overflow;   assign dut_unf[0] = bus_4w.underflow;
    assign dut_ovf[1] = bus_4s.overflow;   assign dut_unf[1] = bus_4s.underflow;
    assign dut_ovf[2] = bus_1w.overflow;   assign dut_unf[2] = bus_1w.underflow;
    assign dut_ovf[3] = bus_8w.overflow;   assign dut_unf[3] = bus_8w.underflow;
    assign dut_max[0] = bus_4w.at_max;     assign dut_zero[0] = bus_4w.at_zero;
    assign dut_max[1] = bus_4s.at_max;     assign dut_zero[1] = bus_4s.at_zero;
    assign dut_max[2] = bus_1w.at_max;     assign dut_zero[2] = bus_1w.at_zero;
    assign dut_max[3] = bus_8w.at_max;     assign dut_zero[3] = bus_8w.at_zero;

    int    cfg_digits [NUM] = '{4, 4, 1, 8};
    bit    cfg_sat    [NUM] = '{1'b0, 1'b1, 1'b0, 1'b0};
    string cfg_name   [NUM] = '{"d4w", "d4s", "d1w", "d8w"};

    // Reference state: the count as a plain decimal integer.
    int unsigned model_count [NUM];
    bit          model_ovf   [NUM];
    bit          model_unf   [NUM];

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int unsigned pow10(input int n);
        int unsigned r = 1;
        repeat (n) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v, input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r = r | (32'(v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int unsigned clamp_value(input logic [31:0] lv, input int nd);
        int unsigned v = 0;
        for (int i = 0; i < nd; i++) begin
            int unsigned nib = 32'((lv >> (4 * i)) & 32'hF);
            if (nib > 9) nib = 9;
            v = v + nib * pow10(i);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM; k++) begin
            model_count[k] = 0;
            model_ovf[k]   = 1'b0;
            model_unf[k]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NUM; k++) begin
            int unsigned maxv = pow10(cfg_digits[k]) - 1;
            model_ovf[k] = 1'b0;
            model_unf[k] = 1'b0;
            if (clr) begin
                model_count[k] = 0;
            end else if (load) begin
                model_count[k] = clamp_value(load_value, cfg_digits[k]);
            end else if (inc && !dec) begin
                if (model_count[k] == maxv) begin
                    model_ovf[k] = 1'b1;
                    if (!cfg_sat[k]) model_count[k] = 0;
                end else begin
                    model_count[k] = model_count[k] + 1;
                end
            end else if (dec && !inc) begin
                if (model_count[k] == 0) begin
                    model_unf[k] = 1'b1;
                    if (!cfg_sat[k]) model_count[k] = maxv;
                end else begin
                    model_count[k] = model_count[k] - 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NUM; k++) begin
            int unsigned maxv = pow10(cfg_digits[k]) - 1;
            check_output({tag, "/", cfg_name[k], ".count"}, dut_count[k], to_bcd(model_count[k], cfg_digits[k]));
            check_output({tag, "/", cfg_name[k], ".overflow"}, 32'(dut_ovf[k]), 32'(model_ovf[k]));
            check_output({tag, "/", cfg_name[k], ".underflow"}, 32'(dut_unf[k]), 32'(model_unf[k]));
            check_output({tag, "/", cfg_name[k], ".at_max"}, 32'(dut_max[k]), 32'(model_count[k] == maxv));
            check_output({tag, "/", cfg_name[k], ".at_zero"}, 32'(dut_zero[k]), 32'(model_count[k] == 0));
        end
    endtask

    task automatic apply_stimulus(input string tag, input bit c, input bit l, input logic [31:0] lv,
                                  input bit i, input bit d);
        clr        = c;
        load       = l;
        load_value = lv;
        inc        = i;
        dec        = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        load       = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;
        load_value = '0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        repeat (12) apply_stimulus("s1_inc", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_output("s1_twelve", dut_count[0], 32'h0000_0012);

        apply_stimulus("s2_load0999", 1'b0, 1'b1, 32'h0000_0999, 1'b0, 1'b0);
        apply_stimulus("s2_inc_ripple", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_output("s2_1000", dut_count[0], 32'h0000_1000);
        apply_stimulus("s2_load1000", 1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        apply_stimulus("s2_dec_ripple", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_output("s2_0999", dut_count[0], 32'h0000_0999);

        apply_stimulus("s3_load_max", 1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b0);
        repeat (3) apply_stimulus("s3_inc_at_max", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_output("s4_sat_hold", dut_count[1], 32'h0000_9999);
        apply_stimulus("s3_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        apply_stimulus("s3_clr", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        apply_stimulus("s3_dec_at_zero", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_output("s3_wrap_9s", dut_count[3], 32'h9999_9999);
        apply_stimulus("s3_dec_again", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        apply_stimulus("s5_clr_load_inc", 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        apply_stimulus("s5_load_inc", 1'b0, 1'b1, 32'h8765_4321, 1'b1, 1'b0);
        apply_stimulus("s5_inc_dec", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        apply_stimulus("s5_load_max", 1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b0);
        apply_stimulus("s5_inc_dec_max", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        apply_stimulus("s6_clamp", 1'b0, 1'b1, 32'hFC3B_A5F3, 1'b0, 1'b0);
        check_output("s6_9593", dut_count[0], 32'h0000_9593);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst_n = 1'b1;

        repeat (400) begin
            bit          c  = ($urandom_range(0, 19) == 0);
            bit          l  = ($urandom_range(0, 7) == 0);
            logic [31:0] lv = ($urandom_range(0, 3) == 0) ? 32'h9999_9999 : 32'($urandom());
            bit          i  = 1'($urandom_range(0, 1));
            bit          d  = ($urandom_range(0, 2) == 0);
            apply_stimulus("rand", c, l, lv, i, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
